switch_port_arbiter: RTL and testbench

Per-output round-robin arbiter and registered output stage for the 4-port packet switch. It resolves contention when several input ports address the same output port in one cycle, and back-pressures the losing inputs through `ready_in`. It forwards each granted byte to its output lane with one cycle of latency. The block sits between the switch's input port logic and the `data_out`/`valid_out` lanes that the switch assertion checker observes.

---
 rtl/switch_port_arbiter.sv | 114 +++++++++++
 tb/tb_switch_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_arbiter.sv
// Per-output round-robin arbiter with a registered, pipeline-through output stage.
// Inputs addressing a nonexistent port are accepted and reported on drop_out.
module switch_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int SRC_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             valid_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_in,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_in,
  output logic [NUM_PORTS-1:0]             ready_in,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  data_out,
  output logic [NUM_PORTS-1:0]             valid_out,
  output logic [NUM_PORTS*SRC_WIDTH-1:0]   src_out,
  input  logic [NUM_PORTS-1:0]             ready_out,
  output logic [NUM_PORTS-1:0]             drop_out
);

  localparam logic [ADDR_WIDTH-1:0] NUM_PORTS_A = ADDR_WIDTH'(NUM_PORTS);

  logic [NUM_PORTS-1:0][SRC_WIDTH-1:0]  ptr_q, ptr_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_PORTS-1:0][SRC_WIDTH-1:0]  src_q, src_d;
  logic [NUM_PORTS-1:0]                 valid_q, valid_d;
  logic [NUM_PORTS-1:0]                 drop_q, drop_d;

  logic [NUM_PORTS-1:0]                 ready_s;
  logic [NUM_PORTS-1:0]                 found_s;
  logic [NUM_PORTS-1:0][SRC_WIDTH-1:0]  gsel_s;
  logic [SRC_WIDTH-1:0]                 idx_s;

  // Arbitration, output-stage next state and illegal-address drops
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    drop_d  = '0;
    ready_s = '0;
    found_s = '0;
    gsel_s  = '0;
    idx_s   = '0;

    for (int o = 0; o < NUM_PORTS; o++) begin
      if (valid_q[o] && ready_out[o]) begin
        valid_d[o] = 1'b0;
      end else begin
        valid_d[o] = valid_q[o];
      end

      // Scan cyclically from the pointer; the first hit wins
      if (!reset && (!valid_q[o] || ready_out[o])) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx_s = SRC_WIDTH'((int'(ptr_q[o]) + k) % NUM_PORTS);
          if (!found_s[o] && valid_in[idx_s] &&
              (addr_in[idx_s*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(o))) begin
            found_s[o] = 1'b1;
            gsel_s[o]  = idx_s;
          end else begin
            found_s[o] = found_s[o];
          end
        end
      end else begin
        found_s[o] = 1'b0;
      end

      if (found_s[o]) begin
        ready_s[gsel_s[o]] = 1'b1;
        data_d[o]  = data_in[gsel_s[o]*DATA_WIDTH +: DATA_WIDTH];
        src_d[o]   = gsel_s[o];
        valid_d[o] = 1'b1;
        ptr_d[o]   = SRC_WIDTH'((int'(gsel_s[o]) + 1) % NUM_PORTS);
      end else begin
        ptr_d[o] = ptr_q[o];
      end
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!reset && valid_in[i] && (addr_in[i*ADDR_WIDTH +: ADDR_WIDTH] >= NUM_PORTS_A)) begin
        ready_s[i] = 1'b1;
        drop_d[i]  = 1'b1;
      end else begin
        drop_d[i] = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= '0;
      drop_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign ready_in  = ready_s;
  assign data_out  = data_q;
  assign src_out   = src_q;
  assign valid_out = valid_q;
  assign drop_out  = drop_q;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Directed and randomized checks of switch_port_arbiter against a behavioural model.
module tb_switch_port_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid_in;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [3:0]  ready_in;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic [7:0]  src_out;
  logic [3:0]  ready_out;
  logic [3:0]  drop_out;

  int total = 0;
  int bad   = 0;

  logic       m_valid [N];
  logic [7:0] m_data  [N];
  int         m_src   [N];
  int         m_ptr   [N];
  logic [3:0] m_drop;
  int         gnt     [N];
  logic [3:0] exp_rdy;
  logic [3:0] rdy_seen;

  logic       pv [N];
  logic [7:0] pa [N];
  logic [7:0] pd [N];

  switch_port_arbiter dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .addr_in(addr_in),
    .data_in(data_in), .ready_in(ready_in), .data_out(data_out),
    .valid_out(valid_out), .src_out(src_out), .ready_out(ready_out),
    .drop_out(drop_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int i);
    return int'(addr_in[i*8 +: 8]);
  endfunction

  // Winner = requester with the smallest cyclic distance from the pointer
  task automatic predict();
    int best;
    int d;
    exp_rdy = 4'b0000;
    for (int o = 0; o < N; o++) begin
      gnt[o] = -1;
      if (!reset && !(m_valid[o] && !ready_out[o])) begin
        best = N;
        for (int i = 0; i < N; i++) begin
          if (valid_in[i] && addr_of(i) == o) begin
            d = (i - m_ptr[o] + N) % N;
            if (d < best) begin
              best = d;
              gnt[o] = i;
            end
          end
        end
        if (gnt[o] >= 0) exp_rdy[gnt[o]] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++)
      if (!reset && valid_in[i] && addr_of(i) >= N) exp_rdy[i] = 1'b1;
  endtask

  task automatic update_model();
    for (int o = 0; o < N; o++) begin
      if (reset) begin
        m_valid[o] = 1'b0; m_data[o] = 8'h00; m_src[o] = 0; m_ptr[o] = 0;
      end else if (gnt[o] >= 0) begin
        m_valid[o] = 1'b1;
        m_data[o]  = data_in[gnt[o]*8 +: 8];
        m_src[o]   = gnt[o];
        m_ptr[o]   = (gnt[o] + 1) % N;
      end else if (ready_out[o]) begin
        m_valid[o] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++)
      m_drop[i] = !reset && valid_in[i] && (addr_of(i) >= N);
  endtask

  task automatic check_outputs();
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [7:0]  es;
    for (int o = 0; o < N; o++) begin
      ev[o] = m_valid[o];
      ed[o*8 +: 8] = m_data[o];
      es[o*2 +: 2] = 2'(m_src[o]);
    end
    check("valid_out", {28'd0, valid_out}, {28'd0, ev});
    check("data_out", data_out, ed);
    check("src_out", {24'd0, src_out}, {24'd0, es});
    check("drop_out", {28'd0, drop_out}, {28'd0, m_drop});
  endtask

  // Inputs are already driven; check ready_in, clock once, check registered outputs
  task automatic cycle();
    #1;
    predict();
    rdy_seen = ready_in;
    check("ready_in", {28'd0, ready_in}, {28'd0, exp_rdy});
    @(posedge clk);
    update_model();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    for (int o = 0; o < N; o++) begin
      m_valid[o] = 1'b0; m_data[o] = 8'h00; m_src[o] = 0; m_ptr[o] = 0;
      pv[o] = 1'b0; pa[o] = 8'h00; pd[o] = 8'h00;
    end
    m_drop    = 4'b0000;
    reset     = 1'b1;
    valid_in  = 4'b0000;
    addr_in   = 32'h0;
    data_in   = 32'h0;
    ready_out = 4'b1111;

    cycle();
    check("reset_valid", {28'd0, valid_out}, 32'd0);
    check("reset_data", data_out, 32'd0);
    reset = 1'b0;
    cycle();

    // single transfer: input 1 -> output 2
    valid_in = 4'b0010; addr_in = 32'h0000_0200; data_in = 32'h0000_A500;
    cycle();
    check("single_rdy", {31'd0, rdy_seen[1]}, 32'd1);
    check("single_valid", {28'd0, valid_out}, 32'h4);
    check("single_data", {24'd0, data_out[23:16]}, 32'hA5);
    check("single_src", {30'd0, src_out[5:4]}, 32'd1);
    valid_in = 4'b0000;

    // contention on output 0 from inputs 0, 1, 3
    valid_in = 4'b1011; addr_in = 32'h0000_0000; data_in = 32'h1300_1110;
    cycle();
    check("cont_rdy0", {28'd0, rdy_seen}, 32'h1);
    check("cont_lane0", {24'd0, data_out[7:0]}, 32'h10);
    valid_in = 4'b1010;
    cycle();
    check("cont_rdy1", {28'd0, rdy_seen}, 32'h2);
    check("cont_lane1", {24'd0, data_out[7:0]}, 32'h11);
    valid_in = 4'b1000;
    cycle();
    check("cont_rdy3", {28'd0, rdy_seen}, 32'h8);
    check("cont_lane3", {24'd0, data_out[7:0]}, 32'h13);
    valid_in = 4'b1001; data_in = 32'h2200_0021;
    cycle();
    check("cont_ptr_wrap", {28'd0, rdy_seen}, 32'h1);
    valid_in = 4'b1000;
    cycle();
    valid_in = 4'b0000;
    cycle();

    // backpressure on output 2
    valid_in = 4'b1000; addr_in = 32'h0200_0000; data_in = 32'h5A00_0000;
    cycle();
    ready_out = 4'b1011;
    valid_in = 4'b0001; addr_in = 32'h0000_0002; data_in = 32'h0000_0077;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("bp_hold_rdy", {31'd0, rdy_seen[0]}, 32'd0);
      check("bp_hold_data", {24'd0, data_out[23:16]}, 32'h5A);
    end
    ready_out = 4'b1111;
    cycle();
    check("bp_release_rdy", {31'd0, rdy_seen[0]}, 32'd1);
    check("bp_release_data", {24'd0, data_out[23:16]}, 32'h77);
    valid_in = 4'b0000;
    cycle();

    // illegal address
    valid_in = 4'b0100; addr_in = 32'h0007_0000; data_in = 32'h00FF_0000;
    cycle();
    check("illegal_rdy", {31'd0, rdy_seen[2]}, 32'd1);
    check("illegal_drop", {28'd0, drop_out}, 32'h4);
    valid_in = 4'b0000;
    cycle();
    check("illegal_drop_clear", {28'd0, drop_out}, 32'h0);

    // full permutation
    valid_in = 4'b1111; addr_in = 32'h0001_0203; data_in = 32'hA3A2_A1A0;
    cycle();
    check("perm_rdy", {28'd0, rdy_seen}, 32'hF);
    check("perm_valid", {28'd0, valid_out}, 32'hF);
    check("perm_data", data_out, 32'hA0A1_A2A3);
    check("perm_src", {24'd0, src_out}, 32'h1B);
    valid_in = 4'b0000;
    cycle();

    // reset while lane 1 is held and inputs request
    valid_in = 4'b0001; addr_in = 32'h0000_0001; data_in = 32'h0000_0033;
    cycle();
    ready_out = 4'b1101; valid_in = 4'b1100; addr_in = 32'h0001_0000;
    data_in = 32'h5566_0000; reset = 1'b1;
    cycle();
    check("rst_rdy", {28'd0, rdy_seen}, 32'h0);
    check("rst_valid", {28'd0, valid_out}, 32'h0);
    check("rst_src", {24'd0, src_out}, 32'h0);
    reset = 1'b0; ready_out = 4'b1111;
    valid_in = 4'b1001; addr_in = 32'h0300_0003; data_in = 32'h9900_0044;
    cycle();
    check("rst_resume_rdy", {28'd0, rdy_seen}, 32'h1);
    check("rst_resume_data", {24'd0, data_out[31:24]}, 32'h44);
    valid_in = 4'b0000;
    cycle();

    // randomized traffic with sources holding requests until accepted
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom_range(0, 2) != 0)) begin
          pv[i] = 1'b1;
          pa[i] = 8'($urandom_range(0, 5));
          pd[i] = 8'($urandom);
        end
        valid_in[i] = pv[i];
        addr_in[i*8 +: 8] = pa[i];
        data_in[i*8 +: 8] = pd[i];
      end
      ready_out = 4'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      cycle();
      for (int i = 0; i < N; i++)
        if (valid_in[i] && rdy_seen[i]) pv[i] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
